fft_ctrl: RTL

FFT_CTRL -- requirements
Module: fft_ctrl

---
 rtl/fft_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/fft_ctrl.sv
// Control sequencer for an in-place radix-2 DIT FFT: bit-reversed load into RAM1,
// then LG ping-pong stages of N/2 butterflies between RAM1 and RAM2.
module fft_ctrl #(
    parameter int N        = 8,
    parameter int BFLY_LAT = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic                           i_load_valid,
    output logic                           o_load_ready,
    output logic                           o_RAM1_wr_en,
    output logic                           o_RAM2_wr_en,
    output logic                           o_RAM1_rd_en,
    output logic                           o_RAM2_rd_en,
    output logic                           o_ROM_rd_en,
    output logic [$clog2(N)-1:0]           o_RAM1_wr_addr,
    output logic [$clog2(N)-1:0]           o_RAM2_wr_addr,
    output logic [$clog2(N)-1:0]           o_RAM1_rd_addr,
    output logic [$clog2(N)-1:0]           o_RAM2_rd_addr,
    output logic [$clog2(N)-2:0]           o_ROM_rd_addr,
    output logic [1:0]                     o_ctrl_RAM1_data,
    output logic [1:0]                     o_ctrl_RAM2_data,
    output logic                           o_ctrl_data,
    output logic                           o_ctrl_even_odd,
    output logic                           o_even_valid,
    output logic                           o_odd_valid,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_result_sel
);

    localparam int LG = $clog2(N);
    localparam int WW = $clog2(BFLY_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RD_EVEN, S_RD_ODD, S_WAIT, S_WR_TOP, S_WR_BOT, S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [LG-1:0]   load_cnt;
    logic [LG-1:0]   stage;
    logic [LG-2:0]   bfly;
    logic [WW-1:0]   wait_cnt;
    logic            even_vld_p1;
    logic            odd_vld_p1;
    logic            even_odd_p1;

    logic            last_bfly;
    logic            last_stage;
    logic            wait_last;
    logic            rd_sel;
    logic [LG-1:0]   half;
    logic [LG-1:0]   pos;
    logic [LG-1:0]   even_addr;
    logic [LG-1:0]   odd_addr;
    logic [LG-1:0]   tw_full;
    logic [LG-1:0]   tw_shift;

    function automatic logic [LG-1:0] bit_rev(input logic [LG-1:0] v);
        logic [LG-1:0] r;
        for (int i = 0; i < LG; i++) begin
            r[i] = v[LG-1-i];
        end
        return r;
    endfunction

    assign last_bfly    = (bfly == (LG-1)'(N/2 - 1));
    assign last_stage   = (stage == LG'(LG - 1));
    assign wait_last    = (wait_cnt == WW'(BFLY_LAT - 1));
    assign rd_sel       = stage[0];
    assign o_result_sel = 1'(LG % 2);

    // Butterfly addressing: span h = 2^s, even = (b/h)*2h + b%h, odd = even + h
    always_comb begin
        half      = LG'(1) << stage;
        pos       = {1'b0, bfly} & (half - LG'(1));
        even_addr = (({1'b0, bfly} >> stage) << (stage + LG'(1))) | pos;
        odd_addr  = even_addr | half;
        tw_shift  = LG'(LG - 1) - stage;
        tw_full   = pos << tw_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (i_start) state_nxt = S_LOAD;
            S_LOAD:    if (i_load_valid && load_cnt == LG'(N - 1)) state_nxt = S_RD_EVEN;
            S_RD_EVEN: state_nxt = S_RD_ODD;
            S_RD_ODD:  state_nxt = S_WAIT;
            S_WAIT:    if (wait_last) state_nxt = S_WR_TOP;
            S_WR_TOP:  state_nxt = S_WR_BOT;
            S_WR_BOT:  state_nxt = (last_bfly && last_stage) ? S_DONE : S_RD_EVEN;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt <= '0;
            stage    <= '0;
            bfly     <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    load_cnt <= '0;
                    stage    <= '0;
                    bfly     <= '0;
                    wait_cnt <= '0;
                end
                S_LOAD: begin
                    if (i_load_valid) load_cnt <= load_cnt + LG'(1);
                end
                S_WAIT: begin
                    wait_cnt <= wait_last ? '0 : wait_cnt + WW'(1);
                end
                S_WR_BOT: begin
                    if (!last_bfly) begin
                        bfly <= bfly + (LG-1)'(1);
                    end else begin
                        bfly <= '0;
                        if (!last_stage) stage <= stage + LG'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read-data qualifiers trail the read request by the one-cycle RAM/ROM latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            even_vld_p1 <= 1'b0;
            odd_vld_p1  <= 1'b0;
            even_odd_p1 <= 1'b0;
        end else begin
            even_vld_p1 <= (state == S_RD_EVEN);
            odd_vld_p1  <= (state == S_RD_ODD);
            if (state == S_RD_EVEN) begin
                even_odd_p1 <= 1'b0;
            end else if (state == S_RD_ODD) begin
                even_odd_p1 <= 1'b1;
            end
        end
    end

    assign o_even_valid    = even_vld_p1;
    assign o_odd_valid     = odd_vld_p1;
    assign o_ctrl_even_odd = even_odd_p1;

    always_comb begin
        o_load_ready     = 1'b0;
        o_RAM1_wr_en     = 1'b0;
        o_RAM2_wr_en     = 1'b0;
        o_RAM1_rd_en     = 1'b0;
        o_RAM2_rd_en     = 1'b0;
        o_ROM_rd_en      = 1'b0;
        o_RAM1_wr_addr   = '0;
        o_RAM2_wr_addr   = '0;
        o_RAM1_rd_addr   = '0;
        o_RAM2_rd_addr   = '0;
        o_ROM_rd_addr    = '0;
        o_ctrl_RAM1_data = 2'b00;
        o_ctrl_RAM2_data = 2'b00;
        o_ctrl_data      = 1'b0;
        o_busy           = (state != S_IDLE);
        o_done           = 1'b0;
        case (state)
            S_LOAD: begin
                o_load_ready = 1'b1;
                o_RAM1_wr_en = i_load_valid;
                if (i_load_valid) o_RAM1_wr_addr = bit_rev(load_cnt);
            end
            S_RD_EVEN, S_RD_ODD: begin
                o_ctrl_data = rd_sel;
                if (rd_sel) begin
                    o_RAM2_rd_en   = 1'b1;
                    o_RAM2_rd_addr = (state == S_RD_EVEN) ? even_addr : odd_addr;
                end else begin
                    o_RAM1_rd_en   = 1'b1;
                    o_RAM1_rd_addr = (state == S_RD_EVEN) ? even_addr : odd_addr;
                end
                if (state == S_RD_ODD) begin
                    o_ROM_rd_en   = 1'b1;
                    o_ROM_rd_addr = tw_full[LG-2:0];
                end
            end
            S_WAIT: begin
                o_ctrl_data = rd_sel;
            end
            S_WR_TOP, S_WR_BOT: begin
                o_ctrl_data = rd_sel;
                if (rd_sel) begin
                    o_RAM1_wr_en     = 1'b1;
                    o_RAM1_wr_addr   = (state == S_WR_TOP) ? even_addr : odd_addr;
                    o_ctrl_RAM1_data = (state == S_WR_TOP) ? 2'b01 : 2'b10;
                end else begin
                    o_RAM2_wr_en     = 1'b1;
                    o_RAM2_wr_addr   = (state == S_WR_TOP) ? even_addr : odd_addr;
                    o_ctrl_RAM2_data = (state == S_WR_TOP) ? 2'b01 : 2'b10;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
